alu_control_seq: RTL and testbench

//  Parametrised successor to the single-cycle ALU decoder, for the multi-cycle RV32IM datapath.

---
 rtl/alu_control_seq.sv | 159 +++++++++++++++
 tb/tb_alu_control_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// ALU operation decoder for the multi-cycle RV32IM datapath.
// Registers the decoded op and sequences multi-cycle mul/div operations.
module alu_control_seq #(
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [6:0] funct7_i,
    input  logic [2:0] ALU_Op_i,
    input  logic [2:0] funct3_i,
    output logic [4:0] ALU_Operation_o,
    output logic       valid_o,
    output logic       illegal_o,
    output logic       md_start_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 2);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 2);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SLL   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_SLT   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_PASSB = 5'b01010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    op_n, base_op, dec_op;
    logic          illegal_n, valid_n, start_n;
    logic          dec_ill, dec_md;

    always_comb begin
        base_op = OP_ADD;
        unique case (funct3_i)
            3'b000: base_op = OP_ADD;
            3'b001: base_op = OP_SLL;
            3'b010: base_op = OP_SLT;
            3'b011: base_op = OP_SLTU;
            3'b100: base_op = OP_XOR;
            3'b101: base_op = OP_SRL;
            3'b110: base_op = OP_OR;
            3'b111: base_op = OP_AND;
        endcase
    end

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        dec_md  = 1'b0;
        case (ALU_Op_i)
            3'b000: begin
                if (funct7_i == F7_BASE) begin
                    dec_op = base_op;
                end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                    dec_op = OP_SUB;
                end else if (funct7_i == F7_ALT && funct3_i == 3'b101) begin
                    dec_op = OP_SRA;
                end else if (funct7_i == F7_M && ENABLE_M) begin
                    dec_op = {2'b10, funct3_i};
                    dec_md = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            3'b001: begin
                if (funct3_i == 3'b001 && funct7_i != F7_BASE) begin
                    dec_ill = 1'b1;
                end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
                    dec_op = OP_SRA;
                end else if (funct3_i == 3'b101 && funct7_i != F7_BASE) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_op = base_op;
                end
            end
            3'b010:  dec_op  = OP_PASSB;
            3'b011:  dec_op  = OP_SUB;
            3'b100:  dec_op  = OP_ADD;
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        op_n      = ALU_Operation_o;
        illegal_n = illegal_o;
        valid_n   = 1'b0;
        start_n   = 1'b0;
        ready_o   = (state == IDLE);
        // Flush wins over an incoming request; the held op code is kept.
        if (flush_i) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_n      = dec_op;
                        illegal_n = dec_ill;
                        if (dec_md) begin
                            start_n = 1'b1;
                            state_n = BUSY;
                            cnt_n   = funct3_i[2] ? DIV_CNT : MUL_CNT;
                        end else begin
                            valid_n = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                        valid_n = 1'b1;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            ALU_Operation_o <= OP_ADD;
            illegal_o       <= 1'b0;
            valid_o         <= 1'b0;
            md_start_o      <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            ALU_Operation_o <= op_n;
            illegal_o       <= illegal_n;
            valid_o         <= valid_n;
            md_start_o      <= start_n;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized bench for alu_control_seq against an event-schedule model.
// A second instance without the M extension covers the illegal-M path.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush, valid, valid0, flush0;
    logic [6:0] funct7;
    logic [2:0] alu_op, funct3;
    logic       ready, vout, ill, start;
    logic [4:0] code;
    logic       ready0, vout0, ill0, start0;
    logic [4:0] code0;

    int checks = 0;
    int errors = 0;
    int cyc;
    int ready_at, valid_at, start_at;
    logic [4:0] m_code;
    logic       m_ill;

    localparam int MUL_L = 2;
    localparam int DIV_L = 4;
    localparam logic [4:0] BASE [8] = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};

    alu_control_seq #(.ENABLE_M(1'b1), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .valid_i(valid),
        .ready_o(ready), .funct7_i(funct7), .ALU_Op_i(alu_op),
        .funct3_i(funct3), .ALU_Operation_o(code), .valid_o(vout),
        .illegal_o(ill), .md_start_o(start)
    );

    alu_control_seq #(.ENABLE_M(1'b0), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut0 (
        .clk(clk), .reset(reset), .flush_i(flush0), .valid_i(valid0),
        .ready_o(ready0), .funct7_i(funct7), .ALU_Op_i(alu_op),
        .funct3_i(funct3), .ALU_Operation_o(code0), .valid_o(vout0),
        .illegal_o(ill0), .md_start_o(start0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void ref_dec(input logic [6:0] f7, input logic [2:0] aop,
                                    input logic [2:0] f3, output logic [4:0] c,
                                    output logic il, output int lat);
        c   = 5'd0;
        il  = 1'b0;
        lat = 1;
        if (aop == 3'd0) begin
            if (f7 == 7'd0) c = BASE[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) c = 5'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) c = 5'd7;
            else if (f7 == 7'h01) begin
                c   = 5'd16 + 5'(f3);
                lat = (f3 < 3'd4) ? MUL_L : DIV_L;
            end else il = 1'b1;
        end else if (aop == 3'd1) begin
            if (f3 == 3'd1 && f7 != 7'd0) il = 1'b1;
            else if (f3 == 3'd5 && f7 == 7'h20) c = 5'd7;
            else if (f3 == 3'd5 && f7 != 7'd0) il = 1'b1;
            else c = BASE[f3];
        end else if (aop == 3'd2) c = 5'd10;
        else if (aop == 3'd3) c = 5'd1;
        else if (aop == 3'd4) c = 5'd0;
        else il = 1'b1;
        if (il) c = 5'd0;
    endfunction

    task automatic model_reset();
        ready_at = 0;
        valid_at = -1;
        start_at = -1;
        m_code   = 5'd0;
        m_ill    = 1'b0;
    endtask

    task automatic step(input logic v, input logic [6:0] f7, input logic [2:0] aop,
                        input logic [2:0] f3, input logic fl);
        logic [4:0] c;
        logic       il;
        int         lat;
        @(negedge clk);
        check("ready", 32'(ready), 32'(cyc >= ready_at));
        check("valid", 32'(vout), 32'(valid_at == cyc));
        check("md_start", 32'(start), 32'(start_at == cyc));
        check("code", 32'(code), 32'(m_code));
        check("illegal", 32'(ill), 32'(m_ill));
        valid  = v;
        funct7 = f7;
        alu_op = aop;
        funct3 = f3;
        flush  = fl;
        if (fl) begin
            valid_at = -1;
            start_at = -1;
            ready_at = cyc + 1;
        end else if (v && cyc >= ready_at) begin
            ref_dec(f7, aop, f3, c, il, lat);
            m_code = c;
            m_ill  = il;
            if (lat == 1) begin
                valid_at = cyc + 1;
            end else begin
                start_at = cyc + 1;
                valid_at = cyc + lat;
                ready_at = cyc + lat;
            end
        end
        cyc++;
    endtask

    function automatic logic [6:0] pick_f7();
        int r;
        r = int'($urandom_range(0, 7));
        if (r < 3) return 7'h00;
        if (r < 5) return 7'h20;
        if (r < 7) return 7'h01;
        return 7'($urandom);
    endfunction

    initial begin
        reset  = 1'b1;
        flush  = 1'b0;
        flush0 = 1'b0;
        valid  = 1'b0;
        valid0 = 1'b0;
        funct7 = 7'd0;
        alu_op = 3'd0;
        funct3 = 3'd0;
        cyc    = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_code", 32'(code), 32'd0);
        check("rst_valid", 32'(vout), 32'd0);
        reset = 1'b0;

        // ENABLE_M=0: an M-type R op is a single-cycle illegal op
        valid0 = 1'b1;
        funct7 = 7'h01;
        alu_op = 3'd0;
        funct3 = 3'd0;
        @(negedge clk);
        check("m0_valid", 32'(vout0), 32'd1);
        check("m0_illegal", 32'(ill0), 32'd1);
        check("m0_code", 32'(code0), 32'd0);
        check("m0_start", 32'(start0), 32'd0);
        check("m0_ready", 32'(ready0), 32'd1);
        funct7 = 7'h20;
        @(negedge clk);
        check("m0_sub_valid", 32'(vout0), 32'd1);
        check("m0_sub_code", 32'(code0), 32'd1);
        check("m0_sub_illegal", 32'(ill0), 32'd0);
        valid0 = 1'b0;

        // SUB then ADDI back-to-back, then illegal forms
        step(1'b1, 7'h20, 3'd0, 3'd0, 1'b0);
        step(1'b1, 7'h00, 3'd1, 3'd0, 1'b0);
        step(1'b1, 7'h02, 3'd0, 3'd0, 1'b0);
        step(1'b1, 7'h20, 3'd1, 3'd1, 1'b0);
        step(1'b1, 7'h00, 3'd7, 3'd0, 1'b0);
        step(1'b1, 7'h01, 3'd0, 3'd0, 1'b0);
        repeat (2) step(1'b0, 7'h00, 3'd0, 3'd0, 1'b0);
        step(1'b1, 7'h01, 3'd0, 3'd4, 1'b0);
        repeat (5) step(1'b1, 7'h00, 3'd2, 3'd0, 1'b0);
        // DIV flushed two cycles after acceptance
        step(1'b1, 7'h01, 3'd0, 3'd4, 1'b0);
        step(1'b0, 7'h00, 3'd0, 3'd0, 1'b0);
        step(1'b1, 7'h00, 3'd0, 3'd0, 1'b1);
        repeat (4) step(1'b0, 7'h00, 3'd0, 3'd0, 1'b0);

        // Asynchronous reset in the middle of a DIV
        step(1'b1, 7'h01, 3'd0, 3'd5, 1'b0);
        step(1'b0, 7'h00, 3'd0, 3'd0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_valid", 32'(vout), 32'd0);
        check("arst_start", 32'(start), 32'd0);
        check("arst_code", 32'(code), 32'd0);
        check("arst_illegal", 32'(ill), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 600; i++) begin
            logic [2:0] aop;
            aop = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom);
            step($urandom_range(0, 3) != 0, pick_f7(), aop, 3'($urandom),
                 $urandom_range(0, 24) == 0);
        end
        repeat (6) step(1'b0, 7'h00, 3'd0, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
